rgb565_gray_pack_ise: RTL and testbench

Multi-pixel RGB565-to-grayscale custom instruction for the OpenRISC custom-instruction interface. One instruction converts four RGB565 pixels (two in each operand) into four 8-bit full-range luma bytes packed into one 32-bit result. The block sits beside the other ISE modules on the CPU custom-instruction bus. It is used by the camera/grayscale software path to cut instruction count by 4x.

---
 rtl/rgb565_gray_pkg.sv | 23 ++
 rtl/rgb565_gray_lane.sv | 33 +++
 rtl/rgb565_gray_pack_ise.sv | 100 ++++++++++
 tb/tb_rgb565_gray_pack_ise.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rgb565_gray_pkg.sv
// rtl/rgb565_gray_pkg.sv - shared types, constants and channel expansion for the RGB565 gray ISE
package rgb565_gray_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_RED_W   = 54;
    localparam int unsigned DEF_GREEN_W = 183;
    localparam int unsigned DEF_BLUE_W  = 19;
    localparam int unsigned PIXELS      = 4;

    // Bit replication so full-scale 5/6-bit codes map to exactly 8'hFF.
    function automatic logic [7:0] expand_to8(input logic [5:0] v, input logic is6);
        if (is6) begin
            return {v, v[5:4]};
        end
        return {v[4:0], v[4:2]};
    endfunction

endpackage

// File: rtl/rgb565_gray_lane.sv
// rtl/rgb565_gray_lane.sv - combinational RGB565 pixel to 8-bit luma; RGB565_GRAY_BYTESWAP_EN swaps pixel bytes
module rgb565_gray_lane
    import rgb565_gray_pkg::*;
#(
    parameter int unsigned RED_W   = DEF_RED_W,
    parameter int unsigned GREEN_W = DEF_GREEN_W,
    parameter int unsigned BLUE_W  = DEF_BLUE_W
) (
    input  logic [15:0] pixel,
    output logic [7:0]  gray
);

    logic [15:0] px;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;

`ifdef RGB565_GRAY_BYTESWAP_EN
    assign px = {pixel[7:0], pixel[15:8]};
`else
    assign px = pixel;
`endif

    assign r8 = expand_to8({1'b0, px[15:11]}, 1'b0);
    assign g8 = expand_to8(px[10:5], 1'b1);
    assign b8 = expand_to8({1'b0, px[4:0]}, 1'b0);

    // Weights total 256, so the 16-bit sum cannot wrap.
    assign sum  = 16'(r8) * 16'(RED_W) + 16'(g8) * 16'(GREEN_W) + 16'(b8) * 16'(BLUE_W);
    assign gray = 8'(sum >> 8);

endmodule

// File: rtl/rgb565_gray_pack_ise.sv
// rtl/rgb565_gray_pack_ise.sv - four-pixel RGB565 to packed gray custom instruction; option RGB565_GRAY_BYTESWAP_EN
module rgb565_gray_pack_ise
    import rgb565_gray_pkg::*;
#(
    parameter logic [7:0]  customInstructionId = 8'd0,
    parameter int unsigned LANES               = 1,
    parameter int unsigned RED_W               = DEF_RED_W,
    parameter int unsigned GREEN_W             = DEF_GREEN_W,
    parameter int unsigned BLUE_W              = DEF_BLUE_W
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  iseId,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned BATCHES    = PIXELS / LANES;
    localparam logic [1:0]  LAST_BATCH = 2'(BATCHES - 1);

    if (RED_W + GREEN_W + BLUE_W != 256) begin : g_bad_weights
        $error("rgb565_gray_pack_ise: RED_W + GREEN_W + BLUE_W must equal 256");
    end
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("rgb565_gray_pack_ise: LANES must be 1, 2 or 4");
    end

    state_t      state;
    logic [1:0]  batch;
    logic [63:0] pix;
    logic [31:0] acc;

    logic [1:0]  lane_slot [LANES];
    logic [15:0] lane_pix  [LANES];
    logic [7:0]  lane_gray [LANES];

    // Lane l of batch b handles pixel b*LANES+l, which is also its result byte.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_slot[l] = 2'(int'(batch) * LANES + l);
            lane_pix[l]  = pix[{lane_slot[l], 4'b0000} +: 16];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        rgb565_gray_lane #(
            .RED_W   (RED_W),
            .GREEN_W (GREEN_W),
            .BLUE_W  (BLUE_W)
        ) u_lane (
            .pixel (lane_pix[g]),
            .gray  (lane_gray[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            batch  <= 2'd0;
            pix    <= 64'd0;
            acc    <= 32'd0;
            done   <= 1'b0;
            result <= 32'd0;
        end else begin
            done   <= 1'b0;
            result <= 32'd0;
            case (state)
                IDLE: begin
                    if (start && iseId == customInstructionId) begin
                        pix   <= {valueB, valueA};
                        acc   <= 32'd0;
                        batch <= 2'd0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    for (int l = 0; l < LANES; l++) begin
                        acc[{lane_slot[l], 3'b000} +: 8] <= lane_gray[l];
                    end
                    if (batch == LAST_BATCH) begin
                        batch <= 2'd0;
                        state <= DONE;
                    end else begin
                        batch <= batch + 2'd1;
                    end
                end
                DONE: begin
                    done   <= 1'b1;
                    result <= acc;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb565_gray_pack_ise.sv
// tb/tb_rgb565_gray_pack_ise.sv - scoreboard bench running LANES=4, 2 and 1 instances side by side
module tb_rgb565_gray_pack_ise;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] valueA = 32'd0;
    logic [31:0] valueB = 32'd0;
    logic [7:0]  iseId = 8'd0;
    logic [31:0] drv_exp = 32'd0;

    logic        done4, done2, done1;
    logic [31:0] res4, res2, res1;

    always #5 clock = ~clock;

    rgb565_gray_pack_ise #(.LANES(4)) u_dut4 (
        .clock (clock), .reset (reset), .start (start), .valueA (valueA),
        .valueB (valueB), .iseId (iseId), .done (done4), .result (res4)
    );
    rgb565_gray_pack_ise #(.LANES(2)) u_dut2 (
        .clock (clock), .reset (reset), .start (start), .valueA (valueA),
        .valueB (valueB), .iseId (iseId), .done (done2), .result (res2)
    );
    rgb565_gray_pack_ise #(.LANES(1)) u_dut1 (
        .clock (clock), .reset (reset), .start (start), .valueA (valueA),
        .valueB (valueB), .iseId (iseId), .done (done1), .result (res1)
    );

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    exp_t q [3][$];
    int   free_at [3];
    int   lat [3] = '{2, 3, 5};
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [15:0] sw16(input logic [15:0] p);
`ifdef RGB565_GRAY_BYTESWAP_EN
        return {p[7:0], p[15:8]};
`else
        return p;
`endif
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] v);
        return {sw16(v[31:16]), sw16(v[15:0])};
    endfunction

    function automatic logic [7:0] gray_px(input logic [15:0] raw);
        logic [15:0] p;
        int r, g, b;
        p = sw16(raw);
        r = (int'(p[15:11]) << 3) | (int'(p[15:11]) >> 2);
        g = (int'(p[10:5]) << 2) | (int'(p[10:5]) >> 4);
        b = (int'(p[4:0]) << 3) | (int'(p[4:0]) >> 2);
        return 8'((r * 54 + g * 183 + b * 19) / 256);
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        return {gray_px(b[31:16]), gray_px(b[15:0]), gray_px(a[31:16]), gray_px(a[15:0])};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference acceptance model: an instance is free again N+2 edges after accepting.
    always @(posedge clock) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                q[i].delete();
                free_at[i] = 0;
            end else if (start && iseId == 8'h00 && cyc >= free_at[i]) begin
                q[i].push_back('{cyc + lat[i], drv_exp});
                free_at[i] = cyc + lat[i] + 1;
            end
        end
    end

    always @(negedge clock) begin
        logic        d [3];
        logic [31:0] r [3];
        logic        ed;
        logic [31:0] er;
        d[0] = done4; d[1] = done2; d[2] = done1;
        r[0] = res4;  r[1] = res2;  r[2] = res1;
        if (cyc > 0) begin
            for (int i = 0; i < 3; i++) begin
                ed = 1'b0;
                er = 32'd0;
                if (q[i].size() > 0 && q[i][0].due == cyc) begin
                    ed = 1'b1;
                    er = q[i][0].val;
                    void'(q[i].pop_front());
                end
                chk($sformatf("done[lanes_idx%0d]", i), {31'd0, d[i]}, {31'd0, ed});
                chk($sformatf("result[lanes_idx%0d]", i), r[i], er);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] id, input logic [31:0] e);
        valueA  = a;
        valueB  = b;
        iseId   = id;
        drv_exp = e;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
    endtask

    vec_t vecs [5];

    initial begin
        logic [31:0] a, b;
        vecs[0] = '{32'h07E0F800, 32'h001FFFFF, 32'h12FFB635};
        vecs[1] = '{32'h00000000, 32'h00000000, 32'h00000000};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[3] = '{32'h84100821, 32'h0000FFFF, 32'h00FF8205};
        vecs[4] = '{32'hF800001F, 32'h07E0FFFF, 32'hB6FF3512};

        tick(3);
        reset = 1'b0;
        tick(1);

        for (int i = 0; i < 5; i++) begin
            issue(sw(vecs[i].a), sw(vecs[i].b), 8'h00, vecs[i].exp);
            tick(7);
        end

        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            issue(a, b, 8'h00, model(a, b));
            tick(7);
        end

        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 8'h05, 32'hFFFFFFFF);
        tick(7);
        issue(32'h07E0F800, 32'h001FFFFF, 8'h80, 32'h12FFB635);
        tick(7);

        // start held high with changing operands: only idle instances accept
        iseId = 8'h00;
        start = 1'b1;
        for (int k = 0; k < 14; k++) begin
            a = $urandom;
            b = $urandom;
            valueA  = a;
            valueB  = b;
            drv_exp = model(a, b);
            tick(1);
        end
        start = 1'b0;
        tick(8);

        // reset two edges into an operation, then reset colliding with start
        issue(32'h12345678, 32'h9ABCDEF0, 8'h00, 32'h0);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2);
        reset   = 1'b1;
        valueA  = 32'hFFFFFFFF;
        valueB  = 32'hFFFFFFFF;
        drv_exp = 32'hFFFFFFFF;
        start   = 1'b1;
        tick(1);
        reset = 1'b0;
        start = 1'b0;
        tick(3);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 32'hFFFFFFFF);
        tick(8);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("pending[lanes_idx%0d]", i), 32'(q[i].size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
